// File: rtl/udp_payload_extract.sv
// udp_payload_extract: parses Ethernet/IPv4/UDP headers from the MAC RX stream and
// forwards only the UDP payload of frames addressed to this node; other frames are counted and dropped.
module udp_payload_extract #(
   parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8010A,
   parameter logic [15:0] UDP_PORT  = 16'd5000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [7:0]  s_tdata,
   input  logic        s_tlast,
   input  logic        s_tuser,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic [7:0]  m_tdata,
   output logic        m_tlast,
   output logic        m_tuser,
   output logic [15:0] rx_count,
   output logic [15:0] drop_count
);
   localparam logic [1:0] S_HDR = 2'd0, S_PAY = 2'd1, S_DRAIN = 2'd2;
   logic [1:0]  r_state;
   logic [5:0]  r_idx;
   logic [15:0] r_remain, r_len, r_rx, r_drop;
   logic        r_uc, r_bc, r_rdy;
   logic [7:0]  w_mac, w_exp, w_msk;
   logic        w_pay, w_acc, w_uc, w_bc, w_ok;
   assign w_pay      = r_state == S_PAY;
   assign s_tready   = w_pay ? m_tready : r_rdy;
   assign w_acc      = s_tvalid & s_tready;
   assign m_tvalid   = w_pay & s_tvalid;
   assign m_tdata    = s_tdata;
   assign m_tlast    = w_pay & (r_remain == 16'd1 | s_tlast);
   assign m_tuser    = w_pay & s_tlast & (r_remain != 16'd1 | s_tuser);
   assign rx_count   = r_rx;
   assign drop_count = r_drop;
   always_comb begin
      w_mac = 8'h00;
      w_exp = 8'h00;
      w_msk = 8'h00;
      case (r_idx)
         6'd0:  w_mac = LOCAL_MAC[47:40];
         6'd1:  w_mac = LOCAL_MAC[39:32];
         6'd2:  w_mac = LOCAL_MAC[31:24];
         6'd3:  w_mac = LOCAL_MAC[23:16];
         6'd4:  w_mac = LOCAL_MAC[15:8];
         6'd5:  w_mac = LOCAL_MAC[7:0];
         6'd12: {w_exp, w_msk} = 16'h08FF;
         6'd13: {w_exp, w_msk} = 16'h00FF;
         6'd14: {w_exp, w_msk} = 16'h45FF;
         6'd20: {w_exp, w_msk} = 16'h003F;
         6'd21: {w_exp, w_msk} = 16'h00FF;
         6'd23: {w_exp, w_msk} = 16'h11FF;
         6'd30: {w_exp, w_msk} = {LOCAL_IP[31:24], 8'hFF};
         6'd31: {w_exp, w_msk} = {LOCAL_IP[23:16], 8'hFF};
         6'd32: {w_exp, w_msk} = {LOCAL_IP[15:8], 8'hFF};
         6'd33: {w_exp, w_msk} = {LOCAL_IP[7:0], 8'hFF};
         6'd36: {w_exp, w_msk} = {UDP_PORT[15:8], 8'hFF};
         6'd37: {w_exp, w_msk} = {UDP_PORT[7:0], 8'hFF};
         default: ;
      endcase
   end
   // unicast and broadcast destination matches are tracked separately across the 6 MAC bytes
   assign w_uc = (r_idx == 6'd0 | r_uc) & (s_tdata == w_mac);
   assign w_bc = (r_idx == 6'd0 | r_bc) & (s_tdata == 8'hFF);
   assign w_ok = (r_idx < 6'd6) ? (w_uc | w_bc) : ((s_tdata & w_msk) == w_exp);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_HDR;
         r_idx    <= 6'd0;
         r_remain <= 16'd0;
         r_len    <= 16'd0;
         r_rx     <= 16'd0;
         r_drop   <= 16'd0;
         r_uc     <= 1'b0;
         r_bc     <= 1'b0;
         r_rdy    <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_acc) begin
            case (r_state)
               S_HDR: begin
                  if (r_idx < 6'd6) begin
                     r_uc <= w_uc;
                     r_bc <= w_bc;
                  end
                  if (r_idx == 6'd38) r_len[15:8] <= s_tdata;
                  if (r_idx == 6'd39) r_len[7:0] <= s_tdata;
                  if (!w_ok || (s_tlast && r_idx != 6'd41)) begin
                     r_drop  <= r_drop + 16'd1;
                     r_idx   <= 6'd0;
                     r_state <= s_tlast ? S_HDR : S_DRAIN;
                  end else if (r_idx == 6'd41) begin
                     r_idx <= 6'd0;
                     if (r_len < 16'd8) begin
                        r_drop  <= r_drop + 16'd1;
                        r_state <= s_tlast ? S_HDR : S_DRAIN;
                     end else begin
                        r_rx     <= r_rx + 16'd1;
                        r_remain <= r_len - 16'd8;
                        r_state  <= s_tlast ? S_HDR : (r_len == 16'd8 ? S_DRAIN : S_PAY);
                     end
                  end else begin
                     r_idx <= r_idx + 6'd1;
                  end
               end
               S_PAY: begin
                  r_remain <= r_remain - 16'd1;
                  if (m_tlast) r_state <= s_tlast ? S_HDR : S_DRAIN;
               end
               S_DRAIN: if (s_tlast) r_state <= S_HDR;
               default: r_state <= S_HDR;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_udp_payload_extract.sv
// tb_udp_payload_extract: table-driven frame vectors plus a mid-frame reset sequence.
module tb_udp_payload_extract;
   logic        clk = 1'b0, resetn = 1'b0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b1;
   logic [7:0]  s_tdata = 8'h00;
   logic        s_tready, m_tvalid, m_tlast, m_tuser;
   logic [7:0]  m_tdata;
   logic [15:0] rx_count, drop_count;
   int          n_chk = 0, n_fail = 0, exp_rx = 0, exp_drop = 0, pos;
   logic [7:0]  frm[$];

   udp_payload_extract dut (
      .clk(clk), .resetn(resetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .rx_count(rx_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] mac;
      logic [15:0] et;
      logic [31:0] ip;
      logic [15:0] port, ulen;
      int npay, npad, trunc;
      bit user, tog;
      int exp_n;
      bit exp_user;
      int d_rx, d_drop;
   } vec_t;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic push16(input logic [15:0] v);
      frm.push_back(v[15:8]);
      frm.push_back(v[7:0]);
   endtask

   task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [31:0] ip,
                        input logic [15:0] port, input logic [15:0] ulen, input int npay, input int npad,
                        input int trunc);
      logic [31:0] sip;
      sip = 32'hC0A80101;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(mac[8*(5-i) +: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'h02);
      push16(et);
      push16(16'h4500);
      push16(ulen + 16'd20);
      push16(16'h0000);
      push16(16'h4000);
      push16(16'h4011);
      push16(16'h0000);
      push16(sip[31:16]);
      push16(sip[15:0]);
      push16(ip[31:16]);
      push16(ip[15:0]);
      push16(16'd5000);
      push16(port);
      push16(ulen);
      push16(16'h0000);
      for (int i = 0; i < npay; i++) frm.push_back(8'(i + 1));
      for (int i = 0; i < npad; i++) frm.push_back(8'hEE);
      if (trunc > 0) while (frm.size() > trunc) void'(frm.pop_back());
   endtask

   // drives frm byte-by-byte; every output byte k must carry payload value k+1
   task automatic run_frame(input bit user, input bit tog, input int exp_n, input bit exp_user,
                            input int abort_at, output int p);
      int cnt, cyc;
      bit acc;
      cnt = 0;
      cyc = 0;
      p = 0;
      while (p < frm.size() && cyc < 2000 && !(abort_at >= 0 && cnt >= abort_at)) begin
         s_tvalid = 1'b1;
         s_tdata  = frm[p];
         s_tlast  = (p == frm.size() - 1);
         s_tuser  = s_tlast & user;
         m_tready = !tog || !cyc[0];
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            chk("data", {24'd0, m_tdata}, 32'(8'(cnt + 1)));
            chk("m_tlast", {31'd0, m_tlast}, {31'd0, cnt == exp_n - 1});
            if (cnt == exp_n - 1) chk("m_tuser", {31'd0, m_tuser}, {31'd0, exp_user});
            cnt++;
         end
         acc = s_tvalid && s_tready;
         @(posedge clk);
         #1;
         if (acc) p++;
         cyc++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      m_tready = 1'b1;
      chk("no_timeout", {31'd0, cyc < 2000}, 32'd1);
      if (abort_at < 0) chk("out_count", cnt, exp_n);
   endtask

   localparam logic [47:0] LM = 48'h000A35000001, BC = 48'hFFFFFFFFFFFF;
   localparam logic [31:0] IP = 32'hC0A8010A;
   localparam logic [15:0] P  = 16'd5000;

   initial begin
      vec_t v[15];
      v[0]  = '{LM, 16'h0800, IP, P, 16'd72, 64, 0, 0, 0, 0, 64, 0, 1, 0};
      v[1]  = '{LM, 16'h0800, IP, P, 16'd10, 2, 16, 0, 0, 0, 2, 0, 1, 0};
      v[2]  = '{LM, 16'h0800, IP, P, 16'd72, 64, 0, 0, 0, 0, 64, 0, 1, 0};
      v[3]  = '{LM, 16'h0800, IP, 16'd5001, 16'd72, 64, 0, 0, 0, 0, 0, 0, 0, 1};
      v[4]  = '{LM, 16'h0806, IP, P, 16'd72, 64, 0, 0, 0, 0, 0, 0, 0, 1};
      v[5]  = '{LM, 16'h0800, 32'hC0A8010B, P, 16'd72, 64, 0, 0, 0, 0, 0, 0, 0, 1};
      v[6]  = '{BC, 16'h0800, IP, P, 16'd72, 64, 0, 0, 0, 1, 64, 0, 1, 0};
      v[7]  = '{LM, 16'h0800, IP, P, 16'd72, 20, 0, 0, 0, 0, 20, 1, 1, 0};
      v[8]  = '{LM, 16'h0800, IP, P, 16'd72, 64, 0, 0, 1, 0, 64, 1, 1, 0};
      v[9]  = '{LM, 16'h0800, IP, P, 16'd72, 64, 0, 30, 0, 0, 0, 0, 0, 1};
      v[10] = '{LM, 16'h0800, IP, P, 16'd8, 0, 10, 0, 0, 0, 0, 0, 1, 0};
      v[11] = '{LM, 16'h0800, IP, P, 16'd4, 0, 6, 0, 0, 0, 0, 0, 0, 1};
      v[12] = '{48'hFF0A35000001, 16'h0800, IP, P, 16'd72, 64, 0, 0, 0, 0, 0, 0, 0, 1};
      v[13] = '{LM, 16'h0800, IP, 16'd5001, 16'd72, 64, 0, 0, 1, 0, 0, 0, 0, 1};
      v[14] = '{BC, 16'h0800, IP, P, 16'd9, 1, 0, 0, 0, 0, 1, 0, 1, 0};
      #2;
      chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
      chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
      chk("rst_m_tuser", {31'd0, m_tuser}, 32'd0);
      chk("rst_rx", {16'd0, rx_count}, 32'd0);
      chk("rst_drop", {16'd0, drop_count}, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", {31'd0, s_tready}, 32'd1);
      foreach (v[i]) begin
         build(v[i].mac, v[i].et, v[i].ip, v[i].port, v[i].ulen, v[i].npay, v[i].npad, v[i].trunc);
         run_frame(v[i].user, v[i].tog, v[i].exp_n, v[i].exp_user, -1, pos);
         exp_rx   += v[i].d_rx;
         exp_drop += v[i].d_drop;
         chk($sformatf("rx_count_v%0d", i), {16'd0, rx_count}, 32'(16'(exp_rx)));
         chk($sformatf("drop_count_v%0d", i), {16'd0, drop_count}, 32'(16'(exp_drop)));
      end
      // reset in the middle of a payload, with a byte still being offered
      build(LM, 16'h0800, IP, P, 16'd72, 64, 0, 0);
      run_frame(1'b0, 1'b0, 64, 1'b0, 10, pos);
      s_tvalid = 1'b1;
      s_tdata  = frm[pos];
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("midrst_s_tready", {31'd0, s_tready}, 32'd0);
      chk("midrst_m_tlast", {31'd0, m_tlast}, 32'd0);
      chk("midrst_rx", {16'd0, rx_count}, 32'd0);
      chk("midrst_drop", {16'd0, drop_count}, 32'd0);
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      frm = frm[pos:$];
      run_frame(1'b0, 1'b0, 0, 1'b0, -1, pos);
      chk("remnant_drop", {16'd0, drop_count}, 32'd1);
      chk("remnant_rx", {16'd0, rx_count}, 32'd0);
      build(LM, 16'h0800, IP, P, 16'd72, 64, 0, 0);
      run_frame(1'b0, 1'b0, 64, 1'b0, -1, pos);
      chk("post_rst_rx", {16'd0, rx_count}, 32'd1);
      chk("post_rst_drop", {16'd0, drop_count}, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
